// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-segment scan driver with frame snapshot,
// per-slot blanking interval and hex decode. Anodes and cathodes are active-low.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    localparam logic [1:0] SLOT_BLANK = 2'd0;
    localparam logic [1:0] SLOT_SHOW  = 2'd1;
    localparam logic [1:0] SLOT_DEAD  = 2'd2;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [5:0]    snap [8];
    logic [5:0]    din  [8];
    logic [5:0]    cur_word;
    logic [1:0]    slot_state;
    logic [7:0]    an_next;
    logic [7:0]    cat_next;

    assign din[0] = d1;
    assign din[1] = d2;
    assign din[2] = d3;
    assign din[3] = d4;
    assign din[4] = d5;
    assign din[5] = d6;
    assign din[6] = d7;
    assign din[7] = d8;

    assign cur_word = snap[idx];

    // Hex digit to gfedcba, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        if (cnt < BLANK_END)
            slot_state = SLOT_BLANK;
        else if (cur_word[5])
            slot_state = SLOT_SHOW;
        else
            slot_state = SLOT_DEAD;
    end

    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
        an_next  = 8'hFF;
        cat_next = 8'hFF;
        case (slot_state)
            SLOT_SHOW: begin
                an_next[idx] = 1'b0;
                cat_next     = {cur_word[0], seg_decode(cur_word[4:1])};
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the snapshot array is reset explicitly so a fresh scan shows dead digits, never stale data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) snap[k] <= 6'h00;
        end else if (cnt == '0 && idx == 3'd0) begin
            for (int k = 0; k < 8; k++) snap[k] <= din[k];
        end
    end

    // Registered outputs; the blank slot at cnt==0 separates any two lit anodes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an      <= 8'hFF;
            dec_cat <= 8'hFF;
        end else begin
            an      <= an_next;
            dec_cat <= cat_next;
        end
    end

endmodule
